sio_host: RTL and testbench

SIO_HOST -- requirements
Module: sio_host

---
 rtl/sio_pkg.sv | 31 +++
 rtl/sio_byte_deser.sv | 34 +++
 rtl/sio_host.sv | 179 +++++++++++++++++
 tb/tb_sio_host.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_pkg.sv
// Shared constants, command type and helpers for the serial link host.
package sio_pkg;

    localparam int unsigned FRAME_LEN      = 128;
    localparam int unsigned CMD_BITS       = 20;
    localparam int unsigned SLOT_FIRST_ADC = 3;
    localparam int unsigned SLOT_LAST_ADC  = 26;
    localparam int unsigned SLOT_MARKER    = 27;
    localparam int unsigned SLOT_RSP       = 28;
    localparam int unsigned PAIRS_PER_BYTE = 4;
    // Last frame cycle carrying command bits, first cycle of the turnaround drive tail.
    localparam int unsigned TX_LAST_FC     = 10;
    localparam int unsigned OE_TAIL_FC     = 124;

    localparam logic [7:0]  MARKER    = 8'hFF;
    localparam logic [3:0]  NOP_ADDR  = 4'h0;
    localparam logic [15:0] NOP_WDATA = 16'h0000;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] wdata;
    } sio_cmd_t;

    localparam sio_cmd_t NOP_CMD = '{addr: NOP_ADDR, wdata: NOP_WDATA};

    // Increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sio_byte_deser.sv
// Two-bits-per-clock to byte deserializer; first pair received lands in the byte MSBs.
module sio_byte_deser
    import sio_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] di,
    output logic [7:0] data,
    output logic       done
);

    logic [5:0] sr_q;
    logic [1:0] cnt_q;

    // The completed byte is presented combinationally on the fourth pair.
    assign data = {sr_q, di};
    assign done = en && (cnt_q == 2'(PAIRS_PER_BYTE - 1));

    // Shift in one pair per enabled cycle; clr realigns the pair count at frame start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            sr_q  <= {sr_q[3:0], di};
            cnt_q <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/sio_host.sv
// Serial link host: one 20-bit command out and 26 target bytes back per 128-cycle frame.
// Link outputs are registered, so pins show frame cycle N one clock after fc reaches N.
module sio_host
    import sio_pkg::*;
#(
    parameter int unsigned RX_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [1:0]  di,
    output logic [1:0]  dout,
    output logic        oe,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        smp_valid,
    output logic [7:0]  smp_data,
    output logic [4:0]  smp_index,
    output logic        rsp_valid,
    output logic [3:0]  rsp_addr,
    output logic [7:0]  rsp_data,
    output logic [7:0]  err_count
);

    localparam logic [6:0] FC_TX_LAST = 7'(TX_LAST_FC);
    localparam logic [6:0] FC_OE_TAIL = 7'(OE_TAIL_FC);
    localparam logic [6:0] RX_FIRST   = 7'(PAIRS_PER_BYTE * SLOT_FIRST_ADC + RX_DELAY);
    localparam logic [6:0] RX_LAST    = 7'(PAIRS_PER_BYTE * (SLOT_RSP + 1) + RX_DELAY - 1);
    localparam logic [4:0] SLOT_FIRST = 5'(SLOT_FIRST_ADC);
    localparam logic [4:0] SLOT_LAST  = 5'(SLOT_LAST_ADC);
    localparam logic [4:0] SLOT_MRK   = 5'(SLOT_MARKER);
    localparam logic [4:0] SLOT_RB    = 5'(SLOT_RSP);

    logic [6:0] fc_q;
    logic       act_q;
    logic       hold_valid_q;
    sio_cmd_t   hold_q;
    sio_cmd_t   load_cmd;
    logic [19:0] tx_q;
    logic [3:0] frame_addr_q;
    logic [1:0] dout_q, dout_d;
    logic       oe_q, oe_d;
    logic [4:0] slot_q;
    logic       smp_valid_q, rsp_valid_q;
    logic [7:0] smp_data_q, rsp_data_q, err_q;
    logic [4:0] smp_index_q;
    logic [3:0] rsp_addr_q;

    logic       at_fc0, start, accept, frame_on, rx_en, byte_done;
    logic [6:0] rx_fc;
    logic [7:0] rx_byte;

    assign at_fc0   = (fc_q == '0);
    assign start    = at_fc0 && run;
    assign accept   = cmd_valid && !hold_valid_q;
    assign frame_on = at_fc0 ? run : act_q;
    assign load_cmd = hold_valid_q ? hold_q : NOP_CMD;
    // di is sampled against the frame cycle currently visible on the pins.
    assign rx_fc    = fc_q - 7'd1;
    assign rx_en    = act_q && (rx_fc >= RX_FIRST) && (rx_fc <= RX_LAST);

    // Frame counter: free-runs through a frame, parks at 0 while run is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fc_q  <= '0;
            act_q <= 1'b0;
        end else if (at_fc0) begin
            fc_q  <= run ? 7'd1 : 7'd0;
            act_q <= run;
        end else begin
            fc_q <= fc_q + 7'd1;
        end
    end

    // Single-entry command holding register; accept only when empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= NOP_CMD;
        end else if (accept) begin
            hold_valid_q <= 1'b1;
            hold_q       <= '{addr: cmd_addr, wdata: cmd_wdata};
        end else if (start) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Next link pin values for the frame cycle fc_q currently holds.
    always_comb begin
        dout_d = 2'b11;
        oe_d   = 1'b0;
        if (frame_on) begin
            oe_d = (fc_q <= FC_TX_LAST) || (fc_q >= FC_OE_TAIL);
            if (at_fc0) begin
                dout_d = 2'b01;
            end else if (fc_q <= FC_TX_LAST) begin
                dout_d = tx_q[19:18];
            end
        end
    end

    // Command shifter and registered link pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_q         <= '0;
            frame_addr_q <= '0;
            dout_q       <= 2'b11;
            oe_q         <= 1'b0;
        end else begin
            if (start) begin
                tx_q         <= load_cmd;
                frame_addr_q <= load_cmd.addr;
            end else if (act_q && !at_fc0 && (fc_q <= FC_TX_LAST)) begin
                tx_q <= {tx_q[17:0], 2'b00};
            end
            dout_q <= dout_d;
            oe_q   <= oe_d;
        end
    end

    sio_byte_deser u_deser (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (start),
        .en      (rx_en),
        .di      (di),
        .data    (rx_byte),
        .done    (byte_done)
    );

    // Route each completed byte by slot: ADC stream, marker check, or readback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q      <= SLOT_FIRST;
            smp_valid_q <= 1'b0;
            smp_data_q  <= '0;
            smp_index_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
            err_q       <= '0;
        end else begin
            smp_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            if (start) begin
                slot_q <= SLOT_FIRST;
            end else if (byte_done) begin
                slot_q <= slot_q + 5'd1;
                if (slot_q <= SLOT_LAST) begin
                    smp_valid_q <= 1'b1;
                    smp_data_q  <= rx_byte;
                    smp_index_q <= slot_q - SLOT_FIRST;
                end else if (slot_q == SLOT_MRK) begin
                    if (rx_byte != MARKER) begin
                        err_q <= sat_inc8(err_q);
                    end
                end else if (slot_q == SLOT_RB) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= rx_byte;
                    rsp_addr_q  <= frame_addr_q;
                end
            end
        end
    end

    assign dout      = dout_q;
    assign oe        = oe_q;
    assign cmd_ready = !hold_valid_q;
    assign smp_valid = smp_valid_q;
    assign smp_data  = smp_data_q;
    assign smp_index = smp_index_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_sio_host.sv
// Bench for sio_host: random target bytes and commands against a frame-position model.
module tb_sio_host;

    localparam int RX_DELAY = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        run, cmd_valid, cmd_ready, oe;
    logic        smp_valid, rsp_valid;
    logic [1:0]  di, dout;
    logic [3:0]  cmd_addr, rsp_addr;
    logic [15:0] cmd_wdata;
    logic [7:0]  smp_data, rsp_data, err_count;
    logic [4:0]  smp_index;

    always #16 clock = ~clock;

    sio_host #(.RX_DELAY(RX_DELAY)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run),
        .di        (di),
        .dout      (dout),
        .oe        (oe),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .smp_index (smp_index),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .err_count (err_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: visible frame position (-1 idle), held command, target bytes.
    int          pos = -1;
    bit          hold_v = 1'b0;
    logic [19:0] hold_cmd = '0;
    logic [19:0] frame_cmd = '0;
    int          err_exp = 0;
    logic [7:0]  tbytes [0:25];
    int          marker_mode = 0;
    bit          cmd_rand = 1'b0;
    logic [19:0] tx_capt = '0;
    logic [19:0] tx_exp [$];

    task automatic new_target_frame();
        for (int i = 0; i < 26; i++) tbytes[i] = 8'($urandom);
        case (marker_mode)
            0:       tbytes[24] = 8'hFF;
            1:       tbytes[24] = 8'hFE;
            default: tbytes[24] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'hFF;
        endcase
    endtask

    // One clock: advance the model, compare every output, then drive the next inputs.
    task automatic tick();
        int p_prev, k, j;
        bit acc, exp_smp, exp_rsp, exp_oe;
        logic [1:0] exp_dout;
        logic [7:0] b;
        acc = cmd_valid && !hold_v;
        @(posedge clock);
        #1;
        p_prev = pos;
        if (p_prev == -1 || p_prev == 127) begin
            if (run) begin
                pos       = 0;
                frame_cmd = hold_v ? hold_cmd : 20'h0;
                hold_v    = 1'b0;
                new_target_frame();
            end else begin
                pos = -1;
            end
        end else begin
            pos = p_prev + 1;
        end
        if (acc) begin
            hold_v   = 1'b1;
            hold_cmd = {cmd_addr, cmd_wdata};
        end

        exp_smp = 1'b0;
        exp_rsp = 1'b0;
        if (p_prev >= RX_DELAY + 12 && ((p_prev - RX_DELAY) % 4) == 3) begin
            k = (p_prev - RX_DELAY) / 4;
            if (k <= 26) begin
                exp_smp = 1'b1;
                check_eq("smp_data", 32'(smp_data), 32'(tbytes[k-3]));
                check_eq("smp_index", 32'(smp_index), 32'(k - 3));
            end else if (k == 27) begin
                if (tbytes[24] != 8'hFF && err_exp < 255) err_exp++;
            end else if (k == 28) begin
                exp_rsp = 1'b1;
                check_eq("rsp_data", 32'(rsp_data), 32'(tbytes[25]));
                check_eq("rsp_addr", 32'(rsp_addr), 32'(frame_cmd[19:16]));
            end
        end
        check_eq("smp_valid", 32'(smp_valid), 32'(exp_smp));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check_eq("err_count", 32'(err_count), 32'(err_exp));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(!hold_v));

        if (pos < 0) begin
            exp_oe   = 1'b0;
            exp_dout = 2'b11;
        end else begin
            exp_oe = (pos <= 10) || (pos >= 124);
            if (pos == 0) exp_dout = 2'b01;
            else if (pos <= 10) exp_dout = frame_cmd[19-2*(pos-1) -: 2];
            else exp_dout = 2'b11;
        end
        check_eq("oe", 32'(oe), 32'(exp_oe));
        check_eq("dout", 32'(dout), 32'(exp_dout));

        if (pos >= 1 && pos <= 10) begin
            tx_capt = {tx_capt[17:0], dout};
            if (pos == 10 && tx_exp.size() > 0) check_eq("tx_frame_bits", 32'(tx_capt),
                                                         32'(tx_exp.pop_front()));
        end

        if (acc) cmd_valid = 1'b0;
        if (cmd_rand && !cmd_valid && $urandom_range(0, 3) == 0) begin
            cmd_valid = 1'b1;
            cmd_addr  = 4'($urandom);
            cmd_wdata = 16'($urandom);
        end
        // Target answers in byte slots 3..28; outside them the bus carries noise.
        if (pos >= RX_DELAY + 12 && pos <= RX_DELAY + 115) begin
            k  = (pos - RX_DELAY) / 4;
            j  = (pos - RX_DELAY) % 4;
            b  = tbytes[k-3];
            di = b[7-2*j -: 2];
        end else begin
            di = 2'($urandom);
        end
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (pos != p && n < 600) begin
            tick();
            n++;
        end
        check_eq("wait_pos", 32'(pos), 32'(p));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_eq("rst_oe_now", 32'(oe), 32'd0);
        check_eq("rst_dout_now", 32'(dout), 32'd3);
        check_eq("rst_rsp_valid_now", 32'(rsp_valid), 32'd0);
        check_eq("rst_smp_valid_now", 32'(smp_valid), 32'd0);
        pos     = -1;
        hold_v  = 1'b0;
        err_exp = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_smp_data", 32'(smp_data), 32'd0);
        check_eq("rst_smp_index", 32'(smp_index), 32'd0);
        check_eq("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        check_eq("rst_oe", 32'(oe), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd3);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        run       = 1'b0;
        di        = 2'b00;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        for (int i = 0; i < 26; i++) tbytes[i] = 8'hFF;
        #5;
        do_reset();
        repeat (8) tick();

        // Directed: idle first frame, command mid-frame, then a command offered at the
        // load point while the holding register is still full.
        tx_exp.push_back(20'h00000);
        run = 1'b1;
        wait_pos(50);
        cmd_valid = 1'b1;
        cmd_addr  = 4'h2;
        cmd_wdata = 16'hA55A;
        tx_exp.push_back(20'h2A55A);
        wait_pos(127);
        cmd_valid = 1'b1;
        cmd_addr  = 4'h9;
        cmd_wdata = 16'h3C71;
        tx_exp.push_back(20'h93C71);
        n = 0;
        while (tx_exp.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check_eq("tx_queue_drained", 32'(tx_exp.size()), 32'd0);

        // Random commands and occasional bad markers.
        cmd_rand    = 1'b1;
        marker_mode = 2;
        repeat (20 * 128) tick();

        // run dropped mid-frame: frame completes, then the link stays idle.
        cmd_rand = 1'b0;
        wait_pos(40);
        run = 1'b0;
        repeat (400) tick();

        // Reset in the middle of a frame.
        run = 1'b1;
        wait_pos(60);
        do_reset();
        repeat (300) tick();

        // Persistently bad marker drives err_count into saturation.
        cmd_rand    = 1'b1;
        marker_mode = 1;
        repeat (300 * 128) tick();
        check_eq("err_saturated", 32'(err_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

endmodule
